bus_req_mux: RTL and testbench
==============================

// Module: bus_req_mux
// PURPOSE
//  Downstream stage of the testbench round-robin arbiter. Takes NUM master request
//  channels (req/gnt/rvalid, single outstanding), presents them to the arbiter and
//  consumes its one-hot grant. Locks the winner, forwards its transaction to the
//  single memory slave port and routes the response back to that winner only.
//  Sits between core fetch/LSU masters and the tb memory model.
// PARAMETERS
//  NUM      2      number of masters; equals arbiter NUM
//  AW       32     address width
//  DW       32     data width; byte-enable width is DW/8
//  TIMEOUT  1024   max cycles in ADDR or RESP before err is set; 0 disables
// PORTS
//  clk         in   1         clock
//  reset       in   1         synchronous, active-high reset
//  m_req       in   NUM       per-master request; held until m_gnt
//  m_we        in   NUM       per-master write enable
//  m_addr      in   NUM*AW    per-master address, packed [NUM-1:0][AW-1:0]
//  m_wdata     in   NUM*DW    per-master write data
//  m_be        in   NUM*DW/8  per-master byte enables
//  m_gnt       out  NUM       one-cycle accept pulse to the owner
//  m_rvalid    out  NUM       one-cycle response pulse to the owner
//  m_rdata     out  DW        shared read data; valid with the owner's m_rvalid
//  arb_req     out  NUM       request vector to the arbiter
//  arb_grant   in   NUM       one-hot, combinational grant from the arbiter
//  s_req       out  1         slave request
//  s_we/s_addr/s_wdata/s_be  out  1/AW/DW/DW/8  latched owner fields
//  s_gnt       in   1         slave accept
//  s_rvalid    in   1         slave response; arrives >=1 cycle after s_gnt
//  s_rdata     in   DW        slave read data
//  err         out  1         sticky: timeout or protocol violation
// BEHAVIOUR
//  - Reset: state=IDLE, owner=0, all outputs 0, timeout counter 0, err=0.
//  - FSM IDLE->ADDR->RESP->IDLE; one transaction in flight.
//  - IDLE: arb_req=m_req. Any arb_grant bit set -> latch owner index and its
//    we/addr/wdata/be, go to ADDR. No grant -> stay. arb_req=0 outside IDLE, so
//    arbiter priority advances only at arbitration edges.
//  - ADDR: s_req=1 with latched fields. On s_gnt: m_gnt[owner] pulses that cycle, go RESP.
//  - RESP: on s_rvalid: m_rvalid[owner]=1, m_rdata=s_rdata (same cycle, combinational),
//    go IDLE. s_rvalid outside RESP is ignored and sets err.
//  - Latency: m_req to s_req 1 cycle. Back-to-back grant for the next master is
//    possible the cycle after m_rvalid.
//  - Writes also wait for s_rvalid (OBI-style), and rdata is don't-care then.
//  - Timeout: counter clears on each state entry and increments in ADDR/RESP.
//    Reaching TIMEOUT sets err; FSM keeps waiting.
//  - err is also set by:
//    - arb_grant not one-hot in IDLE while m_req!=0
//    - owner dropping m_req in ADDR before m_gnt
//    err clears only on reset.
//  - Reset mid-operation: abandon the transaction, return to IDLE, and suppress any
//    pending m_gnt/m_rvalid. Late slave s_rvalid after reset sets err.
//  - Simultaneous requests: the winner is purely the arbiter's choice.
//    Non-owner requests stay pending with m_gnt=0.
// STRUCTURE
//  - Package tb_bus_pkg:
//    - state_e {IDLE,ADDR,RESP}
//    - owner index width $clog2(NUM) (min 1)
//    - TIMEOUT width constant
//  - Sub-module onehot_to_idx: one-hot grant to binary owner index.
//  - The arbiter is instantiated beside this block, not inside it.
// TESTING
//  - Single read: m_req=01, addr0=0x100; slave gnt at +2, rvalid at +3 with 0xDEADBEEF.
//    Expect s_req 1 cycle after m_req, m_gnt[0] with s_gnt, m_rvalid[0] with rdata=0xDEADBEEF.
//  - Contention: m_req=11 held, slave zero-wait. Grants alternate 0,1,0,1 with no
//    starvation; m_rvalid[1] is never asserted during a master-0 transaction.
//  - Write: m_we[1]=1, addr=0x200, wdata=0x12345678, be=0xF. Expect the s_* fields
//    to match exactly and be stable until s_gnt; m_rvalid[1] pulses once.
//  - Timeout: TIMEOUT=8, slave never asserts s_gnt. Expect err=1 after 8 ADDR cycles,
//    s_req held high, state unchanged.
//  - Reset in RESP: assert reset 1 cycle before s_rvalid. Expect no m_rvalid,
//    state=IDLE, and err=1 from the orphan rvalid (cleared on the next reset).
//  - Spurious s_rvalid in IDLE -> err=1, no m_rvalid pulse.

Source files
------------

// File: rtl/tb_bus_pkg.sv
// Shared types and sizing helpers for the bus request mux.
package tb_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int TIMEOUT_DEF = 1024;

    // Owner index width; a single master still needs one bit.
    function automatic int idx_width(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

    // Timeout counter must be able to hold TIMEOUT itself.
    function automatic int tmo_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

    localparam int TMO_W_DEF = tmo_width(TIMEOUT_DEF);

endpackage

// File: rtl/onehot_to_idx.sv
// One-hot arbiter grant to binary owner index, plus validity flags.
module onehot_to_idx #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         multi
);

    localparam logic [N-1:0] ONE = N'(1);

    // Lowest set bit wins so a malformed grant still resolves deterministically.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any   = |onehot;
    assign multi = (onehot & (onehot - ONE)) != '0;

endmodule

// File: rtl/bus_req_mux.sv
// Locks the arbiter's winner, forwards its single transaction to the slave port
// and routes the response back to that winner only.
//
//  state | meaning
//  IDLE  | arbiter sees m_req; waiting for a grant
//  ADDR  | s_req high with latched owner fields; waiting for s_gnt
//  RESP  | request accepted; waiting for s_rvalid
module bus_req_mux
    import tb_bus_pkg::*;
#(
    parameter int NUM     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM-1:0]                 m_req,
    input  logic [NUM-1:0]                 m_we,
    input  logic [NUM-1:0][AW-1:0]         m_addr,
    input  logic [NUM-1:0][DW-1:0]         m_wdata,
    input  logic [NUM-1:0][DW/8-1:0]       m_be,
    output logic [NUM-1:0]                 m_gnt,
    output logic [NUM-1:0]                 m_rvalid,
    output logic [DW-1:0]                  m_rdata,
    output logic [NUM-1:0]                 arb_req,
    input  logic [NUM-1:0]                 arb_grant,
    output logic                           s_req,
    output logic                           s_we,
    output logic [AW-1:0]                  s_addr,
    output logic [DW-1:0]                  s_wdata,
    output logic [DW/8-1:0]                s_be,
    input  logic                           s_gnt,
    input  logic                           s_rvalid,
    input  logic [DW-1:0]                  s_rdata,
    output logic                           err
);

    localparam int              IW      = idx_width(NUM);
    localparam int              TW      = tmo_width(TIMEOUT);
    localparam logic [TW-1:0]   TMO_LIM = TW'(TIMEOUT);

    state_e          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            gnt_multi;
    logic [TW-1:0]   tmo_cnt;
    logic            in_idle;
    logic            in_addr;
    logic            in_resp;
    logic            leaving;
    logic            tmo_hit;
    logic            err_set;

    onehot_to_idx #(
        .N (NUM),
        .W (IW)
    ) u_onehot_to_idx (
        .onehot (arb_grant),
        .idx    (gnt_idx),
        .any    (gnt_any),
        .multi  (gnt_multi)
    );

    assign in_idle = (state == IDLE);
    assign in_addr = (state == ADDR);
    assign in_resp = (state == RESP);

    assign leaving = (in_idle && gnt_any)
                   || (in_addr && s_gnt)
                   || (in_resp && s_rvalid);

    // Fires on the edge where the counter would reach TIMEOUT; FSM keeps waiting.
    assign tmo_hit = (TIMEOUT > 0) && !in_idle && !leaving
                   && (tmo_cnt != TMO_LIM)
                   && ((tmo_cnt + TW'(1)) == TMO_LIM);

    assign err_set = tmo_hit
                   || (in_idle && (|m_req) && gnt_multi)
                   || (in_addr && !m_req[owner])
                   || (s_rvalid && !in_resp);

    // Arbiter only sees requests while idle so its priority moves once per transaction.
    assign arb_req = (!reset && in_idle) ? m_req : '0;

    // Pulses are gated by reset so an abandoned transaction never reaches the master.
    always_comb begin
        m_gnt    = '0;
        m_rvalid = '0;
        m_rdata  = '0;
        if (!reset && in_addr && s_gnt) begin
            m_gnt[owner] = 1'b1;
        end
        if (!reset && in_resp && s_rvalid) begin
            m_rvalid[owner] = 1'b1;
            m_rdata         = s_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= '0;
            s_req   <= 1'b0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_be    <= '0;
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (err_set) begin
                err <= 1'b1;
            end

            if (leaving) begin
                tmo_cnt <= '0;
            end else if (!in_idle && (TIMEOUT > 0) && (tmo_cnt != TMO_LIM)) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        owner   <= gnt_idx;
                        s_req   <= 1'b1;
                        s_we    <= m_we[gnt_idx];
                        s_addr  <= m_addr[gnt_idx];
                        s_wdata <= m_wdata[gnt_idx];
                        s_be    <= m_be[gnt_idx];
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_gnt) begin
                        s_req <= 1'b0;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (s_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    s_req <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_req_mux.sv
// Directed bench for bus_req_mux with a small round-robin arbiter and slave stub.
module tb_bus_req_mux;
    import tb_bus_pkg::*;

    localparam int NUM     = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;

    logic                       clk;
    logic                       reset;
    logic [NUM-1:0]             m_req;
    logic [NUM-1:0]             m_we;
    logic [NUM-1:0][AW-1:0]     m_addr;
    logic [NUM-1:0][DW-1:0]     m_wdata;
    logic [NUM-1:0][DW/8-1:0]   m_be;
    logic [NUM-1:0]             m_gnt;
    logic [NUM-1:0]             m_rvalid;
    logic [DW-1:0]              m_rdata;
    logic [NUM-1:0]             arb_req;
    logic [NUM-1:0]             arb_grant;
    logic                       s_req;
    logic                       s_we;
    logic [AW-1:0]              s_addr;
    logic [DW-1:0]              s_wdata;
    logic [DW/8-1:0]            s_be;
    logic                       s_gnt;
    logic                       s_rvalid;
    logic [DW-1:0]              s_rdata;
    logic                       err;

    logic                       s_gnt_man;
    logic                       s_rv_man;
    logic                       slave_auto;
    logic                       s_rv_q;
    logic                       force_en;
    logic [NUM-1:0]             force_val;
    logic                       rr_last;
    logic [NUM-1:0]             rr_grant;

    int total;
    int bad;

    bus_req_mux #(
        .NUM     (NUM),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_be      (m_be),
        .m_gnt     (m_gnt),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .arb_req   (arb_req),
        .arb_grant (arb_grant),
        .s_req     (s_req),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_be      (s_be),
        .s_gnt     (s_gnt),
        .s_rvalid  (s_rvalid),
        .s_rdata   (s_rdata),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-master round-robin arbiter; master 0 wins first after reset.
    always_comb begin
        rr_grant = 2'b00;
        if (arb_req == 2'b11) rr_grant = rr_last ? 2'b01 : 2'b10;
        else                  rr_grant = arb_req;
    end

    always_ff @(posedge clk) begin
        if (reset)                rr_last <= 1'b1;
        else if (rr_grant != 2'b00) rr_last <= rr_grant[1];
    end

    assign arb_grant = force_en ? force_val : rr_grant;

    // Zero-wait slave: accepts at once, answers the following cycle.
    always_ff @(posedge clk) begin
        if (reset) s_rv_q <= 1'b0;
        else       s_rv_q <= slave_auto && s_req && s_gnt;
    end

    assign s_gnt    = slave_auto | s_gnt_man;
    assign s_rvalid = s_rv_q | s_rv_man;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        m_req     = '0;
        m_we      = '0;
        s_gnt_man = 1'b0;
        s_rv_man  = 1'b0;
        force_en  = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        m_req      = 2'b01;
        m_we       = '0;
        m_addr     = '0;
        m_wdata    = '0;
        m_be       = '0;
        s_gnt_man  = 1'b0;
        s_rv_man   = 1'b0;
        s_rdata    = '0;
        slave_auto = 1'b0;
        force_en   = 1'b0;
        force_val  = '0;

        // Reset: outputs quiet even with a request pending
        cyc();
        cyc();
        mid();
        chk("rst_arb_req", arb_req, 0);
        chk("rst_s_req", s_req, 0);
        m_req = '0;
        cyc();
        reset = 1'b0;
        mid();
        chk("rst_state", dut.state, IDLE);
        chk("rst_owner", dut.owner, 0);
        chk("rst_err", err, 0);
        chk("rst_m_gnt", m_gnt, 0);
        chk("rst_m_rvalid", m_rvalid, 0);
        chk("rst_m_rdata", m_rdata, 0);

        // Single read, slave grant at +2, response at +3
        cyc();
        m_req     = 2'b01;
        m_addr[0] = 32'h100;
        mid();
        chk("rd_arb_req", arb_req, 2'b01);
        chk("rd_s_req_lat0", s_req, 0);
        cyc();
        mid();
        chk("rd_s_req", s_req, 1);
        chk("rd_s_addr", s_addr, 32'h100);
        chk("rd_s_we", s_we, 0);
        chk("rd_gnt_wait", m_gnt, 0);
        chk("rd_arb_req_busy", arb_req, 0);
        cyc();
        s_gnt_man = 1'b1;
        mid();
        chk("rd_m_gnt", m_gnt, 2'b01);
        cyc();
        s_gnt_man = 1'b0;
        m_req     = '0;
        s_rv_man  = 1'b1;
        s_rdata   = 32'hDEADBEEF;
        mid();
        chk("rd_m_rvalid", m_rvalid, 2'b01);
        chk("rd_m_rdata", m_rdata, 32'hDEADBEEF);
        chk("rd_s_req_off", s_req, 0);
        cyc();
        s_rv_man = 1'b0;
        mid();
        chk("rd_rvalid_off", m_rvalid, 0);
        chk("rd_state_idle", dut.state, IDLE);
        chk("rd_err", err, 0);

        // Contention with zero-wait slave: grants alternate 0,1,0,1
        do_reset();
        m_req      = 2'b11;
        slave_auto = 1'b1;
        s_rdata    = 32'h0000_5A5A;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("ct_arb_req", arb_req, 2'b11);
            chk("ct_idle_gnt", m_gnt, 0);
            cyc();
            mid();
            chk("ct_m_gnt", m_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("ct_addr_rvalid", m_rvalid, 0);
            cyc();
            mid();
            chk("ct_m_rvalid", m_rvalid, (k % 2 == 0) ? 2'b01 : 2'b10);
            cyc();
        end
        m_req      = '0;
        slave_auto = 1'b0;
        mid();
        chk("ct_err", err, 0);

        // Write from master 1; fields latched and stable until s_gnt
        do_reset();
        m_req      = 2'b10;
        m_we       = 2'b10;
        m_addr[1]  = 32'h200;
        m_wdata[1] = 32'h12345678;
        m_be[1]    = 4'hF;
        m_addr[0]  = 32'hBAD0;
        m_wdata[0] = 32'h0BAD_0BAD;
        m_be[0]    = 4'h3;
        mid();
        chk("wr_arb_req", arb_req, 2'b10);
        cyc();
        m_wdata[1] = 32'hCAFEF00D;
        mid();
        chk("wr_s_req", s_req, 1);
        chk("wr_s_we", s_we, 1);
        chk("wr_s_addr", s_addr, 32'h200);
        chk("wr_s_wdata", s_wdata, 32'h12345678);
        chk("wr_s_be", s_be, 4'hF);
        chk("wr_gnt_wait", m_gnt, 0);
        cyc();
        mid();
        chk("wr_s_addr_hold", s_addr, 32'h200);
        chk("wr_s_wdata_hold", s_wdata, 32'h12345678);
        cyc();
        s_gnt_man = 1'b1;
        mid();
        chk("wr_m_gnt", m_gnt, 2'b10);
        chk("wr_s_be_hold", s_be, 4'hF);
        cyc();
        s_gnt_man = 1'b0;
        m_req     = '0;
        m_we      = '0;
        mid();
        chk("wr_resp_wait", m_rvalid, 0);
        chk("wr_s_req_off", s_req, 0);
        cyc();
        s_rv_man = 1'b1;
        mid();
        chk("wr_m_rvalid", m_rvalid, 2'b10);
        cyc();
        s_rv_man = 1'b0;
        mid();
        chk("wr_rvalid_once", m_rvalid, 0);
        chk("wr_err", err, 0);

        // Timeout: slave never grants, err after 8 ADDR cycles
        do_reset();
        m_req     = 2'b01;
        m_addr[0] = 32'h300;
        cyc();
        mid();
        chk("to_first", err, 0);
        for (int i = 2; i <= 8; i++) cyc();
        mid();
        chk("to_cycle8", err, 0);
        cyc();
        mid();
        chk("to_err", err, 1);
        chk("to_s_req", s_req, 1);
        chk("to_state", dut.state, ADDR);
        cyc();
        cyc();
        mid();
        chk("to_still_addr", dut.state, ADDR);
        chk("to_sticky", err, 1);
        do_reset();
        mid();
        chk("to_err_clear", err, 0);

        // Reset one cycle before s_rvalid
        cyc();
        m_req = 2'b01;
        cyc();
        s_gnt_man = 1'b1;
        mid();
        chk("rr_m_gnt", m_gnt, 2'b01);
        cyc();
        s_gnt_man = 1'b0;
        m_req     = '0;
        reset     = 1'b1;
        mid();
        chk("rr_rvalid_rst", m_rvalid, 0);
        cyc();
        reset    = 1'b0;
        s_rv_man = 1'b1;
        s_rdata  = 32'h55AA55AA;
        mid();
        chk("rr_no_rvalid", m_rvalid, 0);
        chk("rr_state", dut.state, IDLE);
        chk("rr_rdata", m_rdata, 0);
        cyc();
        s_rv_man = 1'b0;
        mid();
        chk("rr_orphan_err", err, 1);
        do_reset();
        mid();
        chk("rr_err_clear", err, 0);

        // Spurious s_rvalid in IDLE
        cyc();
        s_rv_man = 1'b1;
        mid();
        chk("sp_no_rvalid", m_rvalid, 0);
        cyc();
        s_rv_man = 1'b0;
        mid();
        chk("sp_err", err, 1);

        // Multi-hot grant while requests pending
        do_reset();
        m_req     = 2'b11;
        force_en  = 1'b1;
        force_val = 2'b11;
        mid();
        chk("mh_pre", err, 0);
        cyc();
        force_en = 1'b0;
        mid();
        chk("mh_err", err, 1);

        // Owner drops m_req in ADDR before grant
        do_reset();
        m_req = 2'b01;
        cyc();
        m_req = 2'b00;
        mid();
        chk("dr_pre", err, 0);
        chk("dr_no_gnt", m_gnt, 0);
        cyc();
        mid();
        chk("dr_err", err, 1);

        // Reset in ADDR suppresses a same-cycle m_gnt
        do_reset();
        m_req = 2'b01;
        cyc();
        reset     = 1'b1;
        s_gnt_man = 1'b1;
        mid();
        chk("ra_no_gnt", m_gnt, 0);
        cyc();
        reset     = 1'b0;
        s_gnt_man = 1'b0;
        m_req     = '0;
        mid();
        chk("ra_s_req", s_req, 0);
        chk("ra_state", dut.state, IDLE);
        chk("ra_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
